banked_register_file: RTL

Parametrised successor to the flat 16-entry register bank: an ARM7-style banked register file with per-mode r13/r14, optional FIQ-banked r8–r12, CPSR plus five SPSRs, a dedicated PC port and three read ports with write-through bypass. It sits between decode and execute. Operand reads are combinational. All state updates are on the rising clock edge, including atomic exception entry and exception return.

---
 rtl/banked_register_file.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/banked_register_file.sv
// ARM7-style banked register file: shared r0-r7 (and r8-r12), per-mode r13/r14/SPSR, CPSR, PC port.
// Optional feature macro REGBANK_FIQ_BANK_EN gives fiq private r8-r12.
module banked_register_file #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] PC_RESET = '0
) (
    input  logic             clock,
    input  logic             in_Reset_n,
    input  logic [3:0]       in_Read_address1,
    input  logic [3:0]       in_Read_address2,
    input  logic [3:0]       in_Read_address3,
    output logic [WIDTH-1:0] out_Data1,
    output logic [WIDTH-1:0] out_Data2,
    output logic [WIDTH-1:0] out_Data3,
    input  logic [3:0]       in_Write_address1,
    input  logic [WIDTH-1:0] in_Write_data1,
    input  logic             in_Write_enable,
    input  logic             in_Pc_write,
    input  logic [WIDTH-1:0] in_Pc_next,
    output logic [WIDTH-1:0] out_Pc,
    input  logic             in_Flags_write,
    input  logic [3:0]       in_Flags,
    input  logic             in_Mode_write,
    input  logic [4:0]       in_Mode,
    input  logic             in_Exception,
    input  logic [4:0]       in_Exception_mode,
    input  logic [WIDTH-1:0] in_Return_address,
    input  logic             in_Spsr_restore,
    output logic [31:0]      out_Cpsr,
    output logic [31:0]      out_Spsr,
    output logic             out_Mode_error
);

    localparam logic [4:0] MODE_USR = 5'b10000;
    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;
    localparam logic [4:0] MODE_SYS = 5'b11111;
    localparam logic [4:0] PHYS_PC  = 5'd31;

    // Physical layout: 0-12 shared, 13-18 r13 per bank, 19-24 r14 per bank, 25-29 fiq r8-r12.
`ifdef REGBANK_FIQ_BANK_EN
    localparam int NPHYS = 30;
`else
    localparam int NPHYS = 25;
`endif

    function automatic logic mode_valid(input logic [4:0] m);
        return (m == MODE_USR) || (m == MODE_FIQ) || (m == MODE_IRQ) || (m == MODE_SVC) ||
               (m == MODE_ABT) || (m == MODE_UND) || (m == MODE_SYS);
    endfunction

    // Bank 0 is usr/sys (and any non-exception encoding); 1..5 are fiq, irq, svc, abt, und.
    function automatic logic [2:0] bank_of(input logic [4:0] m);
        case (m)
            MODE_FIQ: return 3'd1;
            MODE_IRQ: return 3'd2;
            MODE_SVC: return 3'd3;
            MODE_ABT: return 3'd4;
            MODE_UND: return 3'd5;
            default:  return 3'd0;
        endcase
    endfunction

    function automatic logic [4:0] phys(input logic [3:0] a, input logic [2:0] b);
        logic [4:0] p;
        p = {1'b0, a};
        if (a == 4'd13)      p = 5'd13 + {2'b00, b};
        else if (a == 4'd14) p = 5'd19 + {2'b00, b};
        else if (a == 4'd15) p = PHYS_PC;
`ifdef REGBANK_FIQ_BANK_EN
        else if (a >= 4'd8 && b == 3'd1) p = {1'b0, a} + 5'd17;
`endif
        return p;
    endfunction

    logic [WIDTH-1:0] regs_q [NPHYS];
    logic [WIDTH-1:0] regs_d [NPHYS];
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [3:0]       nzcv_q, nzcv_d;
    logic             irq_dis_q, irq_dis_d;
    logic             fiq_dis_q, fiq_dis_d;
    logic [4:0]       mode_q, mode_d;
    logic [31:0]      spsr_q [5];
    logic [31:0]      spsr_d [5];
    logic             mode_err_q, mode_err_d;

    logic [31:0]      cpsr;
    logic [2:0]       cur_bank;
    logic [2:0]       exc_bank;
    logic [31:0]      cur_spsr;
    logic [4:0]       wr_phys;

    assign cpsr     = {nzcv_q, 20'b0, irq_dis_q, fiq_dis_q, 1'b0, mode_q};
    assign cur_bank = bank_of(mode_q);
    assign exc_bank = bank_of(in_Exception_mode);
    assign cur_spsr = (cur_bank == 3'd0) ? 32'h0 : spsr_q[cur_bank - 3'd1];
    assign wr_phys  = phys(in_Write_address1, cur_bank);

    assign out_Pc         = pc_q;
    assign out_Cpsr       = cpsr;
    assign out_Spsr       = cur_spsr;
    assign out_Mode_error = mode_err_q;

    logic [3:0]       rd_addr [3];
    logic [WIDTH-1:0] rd_data [3];

    assign rd_addr[0] = in_Read_address1;
    assign rd_addr[1] = in_Read_address2;
    assign rd_addr[2] = in_Read_address3;
    assign out_Data1  = rd_data[0];
    assign out_Data2  = rd_data[1];
    assign out_Data3  = rd_data[2];

    for (genvar p = 0; p < 3; p++) begin : g_read
        logic [4:0] rd_phys;
        always_comb begin
            rd_phys = phys(rd_addr[p], cur_bank);
            if (in_Write_enable && (wr_phys == rd_phys)) rd_data[p] = in_Write_data1;
            else if (rd_phys == PHYS_PC)                 rd_data[p] = pc_q + WIDTH'(8);
            else                                         rd_data[p] = regs_q[rd_phys];
        end
    end

    always_comb begin
        regs_d     = regs_q;
        spsr_d     = spsr_q;
        pc_d       = pc_q;
        nzcv_d     = nzcv_q;
        irq_dis_d  = irq_dis_q;
        fiq_dis_d  = fiq_dis_q;
        mode_d     = mode_q;
        mode_err_d = mode_err_q;

        if (in_Pc_write) pc_d = in_Pc_next;
        if (in_Write_enable) begin
            if (wr_phys == PHYS_PC) pc_d = {in_Write_data1[WIDTH-1:2], 2'b00};
            else                    regs_d[wr_phys] = in_Write_data1;
        end

        // Exception entry is evaluated after the general write so its r14 load wins a collision.
        if (in_Exception) begin
            if (mode_valid(in_Exception_mode)) begin
                mode_d    = in_Exception_mode;
                irq_dis_d = 1'b1;
                if (in_Exception_mode == MODE_FIQ) fiq_dis_d = 1'b1;
                if (exc_bank != 3'd0) spsr_d[exc_bank - 3'd1] = cpsr;
                regs_d[phys(4'd14, exc_bank)] = in_Return_address;
            end else begin
                mode_err_d = 1'b1;
            end
        end else if (in_Spsr_restore) begin
            if (cur_bank == 3'd0) begin
                mode_err_d = 1'b1;
            end else begin
                nzcv_d    = cur_spsr[31:28];
                irq_dis_d = cur_spsr[7];
                fiq_dis_d = cur_spsr[6];
                mode_d    = cur_spsr[4:0];
            end
        end else if (in_Mode_write) begin
            if (mode_valid(in_Mode)) mode_d = in_Mode;
            else                     mode_err_d = 1'b1;
        end else if (in_Flags_write) begin
            nzcv_d = in_Flags;
        end
    end

    always_ff @(posedge clock) begin
        if (!in_Reset_n) begin
            for (int i = 0; i < NPHYS; i++) regs_q[i] <= '0;
            for (int i = 0; i < 5; i++)     spsr_q[i] <= '0;
            pc_q       <= PC_RESET;
            nzcv_q     <= 4'b0;
            irq_dis_q  <= 1'b1;
            fiq_dis_q  <= 1'b1;
            mode_q     <= MODE_SVC;
            mode_err_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            spsr_q     <= spsr_d;
            pc_q       <= pc_d;
            nzcv_q     <= nzcv_d;
            irq_dis_q  <= irq_dis_d;
            fiq_dis_q  <= fiq_dis_d;
            mode_q     <= mode_d;
            mode_err_q <= mode_err_d;
        end
    end

endmodule
